sn185_bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter: the reverse direction of the team's 6-bit BCD-to-binary converter.
- Uses the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Has a start/busy/valid handshake and the same active-low output gate (g_n) convention.
- Feeds BCD display/decoder logic from binary counters and arithmetic blocks.

---
 rtl/sn185_bin2bcd_seq.sv | 120 ++++++++++++
 tb/tb_sn185_bin2bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sn185_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with start/busy/valid
// handshake and active-low output gate. Define SN185_LEAD_BLANK_EN for leading-zero blanking.
module sn185_bin2bcd_seq #(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  g_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [SH_W-1:0]      sh_q, sh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [SH_W-1:0]      sh_add;
    logic [SH_W-1:0]      sh_next;

`ifdef SN185_LEAD_BLANK_EN
    // Blank upper digits down to (but excluding) the first non-zero digit; digit 0 always shown.
    function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] v);
        logic        lead;
        int unsigned idx;
        blank_lead = v;
        lead       = 1'b1;
        for (int unsigned j = 0; j < DIGITS - 1; j++) begin
            idx = DIGITS - 1 - j;
            if (lead && (v[4*idx +: 4] == 4'd0)) begin
                blank_lead[4*idx +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    endfunction
`else
    function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] v);
        blank_lead = v;
    endfunction
`endif

    always_comb begin
        sh_add = sh_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sh_add[BIN_W + 4*i +: 4] >= 4'd5) begin
                sh_add[BIN_W + 4*i +: 4] = sh_add[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        sh_next = {sh_add[SH_W-2:0], 1'b0};
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (start && !g_n) begin
                    sh_d    = {{BCD_W{1'b0}}, bin_in};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = blank_lead(sh_next[SH_W-1 -: BCD_W]);
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == SHIFT);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign bcd_out = g_n ? '1 : result_q;

endmodule

// File: tb/tb_sn185_bin2bcd_seq.sv
// Bench for sn185_bin2bcd_seq: cycle model from decimal arithmetic plus directed literal checks.
module tb_sn185_bin2bcd_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       g_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] bin_in = '0;
    logic       busy;
    logic       valid;
    logic [7:0] bcd_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    sn185_bin2bcd_seq #(.BIN_W(6), .DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .g_n(g_n), .start(start),
        .bin_in(bin_in), .busy(busy), .valid(valid), .bcd_out(bcd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'(v / 10);
`ifdef SN185_LEAD_BLANK_EN
        if (r[7:4] == 4'd0) r[7:4] = 4'hF;
`endif
        return r;
    endfunction

    // Model: a conversion occupies BIN_W cycles after acceptance, then one result cycle.
    int         m_remain = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_res = '0;
    int         m_op = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_remain = 0;
            m_valid  = 1'b0;
            m_res    = '0;
        end else if (m_remain != 0) begin
            m_remain = m_remain - 1;
            m_valid  = (m_remain == 0);
            if (m_remain == 0) m_res = to_bcd(m_op);
        end else begin
            m_valid = 1'b0;
            if (start && !g_n) begin
                m_remain = 6;
                m_op     = int'(bin_in);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {7'd0, busy}, {7'd0, m_remain != 0});
            check("valid", {7'd0, valid}, {7'd0, m_valid});
            check("bcd_out", bcd_out, g_n ? 8'hFF : m_res);
        end
    end

    task automatic start_conv(input logic [5:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the cycle index (1 = first cycle after acceptance) in which valid was seen, 99 on timeout.
    task automatic wait_valid(output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (valid) seen = 1'b1;
        end
        if (!seen) lat = 99;
    endtask

    task automatic conv(input string name, input logic [5:0] v, input logic [7:0] exp);
        int lat;
        start_conv(v);
        wait_valid(lat);
        check({name, "_lat"}, 8'(lat), 8'd7);
        check(name, bcd_out, exp);
        #1;
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (valid) n++;
        end
        #1;
    endtask

    initial begin
        int lat;
        int nv;
        #2;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_valid", {7'd0, valid}, 8'd0);
        check("rst_bcd", bcd_out, 8'h00);
        @(negedge clk); #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk); #1;

        conv("c63", 6'd63, 8'h63);
        @(negedge clk);
        check("busy_after", {7'd0, busy}, 8'd0);
        #1;
`ifdef SN185_LEAD_BLANK_EN
        conv("c0", 6'd0, 8'hF0);
        conv("c7", 6'd7, 8'hF7);
`else
        conv("c0", 6'd0, 8'h00);
        conv("c7", 6'd7, 8'h07);
`endif
        conv("c10", 6'd10, 8'h10);

        // Second start during SHIFT must be ignored.
        start_conv(6'd45);
        @(negedge clk); #1;
        start_conv(6'd9);
        bin_in = 6'd9;
        wait_valid(lat);
        check("c45_lat", 8'(lat), 8'd6);
        check("c45", bcd_out, 8'h45);
        #1;
        count_valid(12, nv);
        check("c45_single_valid", 8'(nv), 8'd0);

        // Gate high: all ones, starts ignored, result held underneath.
        g_n = 1'b1;
        #1 check("gate_ff", bcd_out, 8'hFF);
        start_conv(6'd20);
        count_valid(10, nv);
        check("gated_start_valid", 8'(nv), 8'd0);
        check("gated_start_busy", {7'd0, busy}, 8'd0);
        g_n = 1'b0;
        #1 check("gate_release", bcd_out, 8'h45);

        // Back-to-back: start presented in the DONE cycle; gate toggled mid-conversion.
        start_conv(6'd45);
        wait_valid(lat);
        check("b2b_first", bcd_out, 8'h45);
        #1 start = 1'b1;
        bin_in = 6'd9;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); #1 g_n = 1'b1;
        @(negedge clk); #1 g_n = 1'b0;
        wait_valid(lat);
        check("b2b_lat", 8'(lat), 8'd5);
`ifdef SN185_LEAD_BLANK_EN
        check("b2b_9", bcd_out, 8'hF9);
`else
        check("b2b_9", bcd_out, 8'h09);
`endif
        #1;

        // Reset during SHIFT aborts with no valid.
        start_conv(6'd50);
        @(negedge clk); #1;
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_valid", {7'd0, valid}, 8'd0);
        check("mid_rst_bcd", bcd_out, 8'h00);
        @(negedge clk); #1 rst_n = 1'b1;
        count_valid(10, nv);
        check("mid_rst_no_valid", 8'(nv), 8'd0);
        conv("c50", 6'd50, 8'h50);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
